id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode→execute pipeline register for the 16-bit pipelined core.
- Captures the 36-bit decoded control bundle, both register operands, the sign-extended immediate, the PC+2 value and the destination register index.
- Applies stall (hold) and flush (bubble insert), and tracks a sticky halt state so the pipeline drains cleanly after a HALT instruction.
- Sits between the decode/hazard logic upstream and the execute stage downstream.

Parameters:
CTRL_W, 36, width of control bundle
DATA_W, 16, width of operands/immediate/PC
HALT_BIT, 35, index of HALT flag inside control bundle

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
stall  input  1  hold all stage contents this cycle
flush  input  1  replace stage contents with a bubble
valid_in  input  1  upstream entry is a real instruction
control_in  input  CTRL_W  decoded control bundle
opa_in  input  DATA_W  register operand A
opb_in  input  DATA_W  register operand B
imm_in  input  DATA_W  extended immediate
pc2_in  input  DATA_W  PC+2 of instruction
rd_in  input  3  destination register index
valid_out  output  1  registered valid
control_out  output  CTRL_W  registered control
opa_out, opb_out, imm_out, pc2_out  output  DATA_W  registered data
rd_out  output  3  registered destination index
halted  output  1  stage in HALTED state
bubble_cnt  output  16  bubble cycle counter (optional feature)

Behaviour:
- Reset (async, rst=1): all outputs 0, state RUN, bubble_cnt 0. Reset mid-operation discards the entry and halt state immediately, without waiting for a clock edge.
- Latency: 1 cycle from inputs to outputs on a load edge.
- Per-edge priority: flush > stall > halted-drain > load.
  - flush=1: valid_out←0, control_out←0, all data←0, rd_out←0. Applies in both states; state unchanged. flush+stall together → flush wins.
  - stall=1 (flush=0): every register holds, including state.
  - State HALTED, no flush/stall: load bubble (same values as flush).
  - State RUN, no flush/stall: load all *_in fields; valid_out←valid_in.
- Bubble definition: valid_out=0, control_out=0. A bubble must be side-effect free downstream.
- State machine (2 states):
  - RUN→HALTED on a load edge where valid_in=1 and control_in[HALT_BIT]=1. The halt entry itself is presented on outputs.
  - HALTED→RUN only via rst.
  - A halt entry offered while stall or flush is active is not loaded and causes no transition.
- halted = (state==HALTED), registered.
- Draining: a halt entry stays on the outputs while stall is held. On the first non-stall edge after entering HALTED, the outputs become a bubble and remain so.
- valid_in=0 with nonzero control_in: loaded verbatim, but valid_out=0. Downstream qualifies on valid_out. The HALT bit is ignored when valid_in=0.

Optional Feature:
Macro IDEX_PERF_EN.
- Defined: bubble_cnt increments by 1 on each clk edge where valid_out is 0 before the edge and rst=0. Saturates at 16'hFFFF (no wrap). Cleared only by rst. Counts stalled bubbles too.
- Undefined: no counter logic; bubble_cnt tied to 16'h0000.

Test Plan:
- Reset: rst=1 mid-stream with valid entry held → all outputs 0 and halted=0 asynchronously, before the next edge.
- Load: valid_in=1, control_in=36'h0_0000_1234, opa_in=16'hBEEF, rd_in=3'd5 → one edge later valid_out=1, control_out=36'h0_0000_1234, opa_out=16'hBEEF, rd_out=5.
- Stall then flush+stall: load opa=16'h0001; stall=1 for 3 edges with opa_in=16'h0002 → opa_out stays 16'h0001. Then flush=1, stall=1 → valid_out=0, control_out=0, opa_out=0.
- Halt drain: load valid entry with control_in[35]=1 → halted=1, entry visible. Hold stall 2 edges → entry held. Release stall → bubble; further valid inputs (16'h5555) never appear; halted stays 1 until rst.
- Ignored halt: valid_in=0 with control_in[35]=1 → halted stays 0; halt entry offered under flush=1 → halted stays 0.
- IDEX_PERF_EN: after reset, 10 edges of valid_in=0 → bubble_cnt=10. Force counter near 16'hFFFF via long bubble run → holds 16'hFFFF. Without macro → bubble_cnt=0 throughout.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with stall/flush and a sticky HALT drain state.
// Optional bubble counter enabled by defining IDEX_PERF_EN.
module id_ex_stage #(
  parameter int CTRL_W   = 36,
  parameter int DATA_W   = 16,
  parameter int HALT_BIT = 35
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] opa_in,
  input  logic [DATA_W-1:0] opb_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc2_in,
  input  logic [2:0]        rd_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] opa_out,
  output logic [DATA_W-1:0] opb_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc2_out,
  output logic [2:0]        rd_out,
  output logic              halted,
  output logic [15:0]       bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
    logic [2:0]        rd;
  } entry_t;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  entry_t in_e, q;
  state_t state;

  assign in_e = {valid_in, control_in, opa_in, opb_in, imm_in, pc2_in, rd_in};

  // An all-zero entry is the bubble: valid and every control bit cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      state <= RUN;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      if (state == HALTED) begin
        q <= '0;
      end else begin
        q <= in_e;
        if (valid_in && control_in[HALT_BIT]) state <= HALTED;
      end
    end
  end

  assign valid_out   = q.valid;
  assign control_out = q.ctrl;
  assign opa_out     = q.opa;
  assign opb_out     = q.opb;
  assign imm_out     = q.imm;
  assign pc2_out     = q.pc2;
  assign rd_out      = q.rd;
  assign halted      = (state == HALTED);

`ifdef IDEX_PERF_EN
  logic [15:0] cnt;
  // Counts every cycle the stage holds a non-valid entry, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              cnt <= '0;
    else if (!q.valid && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign bubble_cnt = cnt;
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed corner sequences,
// and randomized traffic checked against a behavioural reference model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in;
  logic [35:0] control_in;
  logic [15:0] opa_in, opb_in, imm_in, pc2_in;
  logic [2:0]  rd_in;
  logic        valid_out, halted;
  logic [35:0] control_out;
  logic [15:0] opa_out, opb_out, imm_out, pc2_out, bubble_cnt;
  logic [2:0]  rd_out;

  int checks = 0, failures = 0;

  // reference model: what the stage should currently present
  logic        m_valid, m_halted;
  logic [35:0] m_ctrl;
  logic [15:0] m_opa, m_opb, m_imm, m_pc2, m_cnt;
  logic [2:0]  m_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .control_in(control_in), .opa_in(opa_in), .opb_in(opb_in), .imm_in(imm_in),
    .pc2_in(pc2_in), .rd_in(rd_in), .valid_out(valid_out), .control_out(control_out),
    .opa_out(opa_out), .opb_out(opb_out), .imm_out(imm_out), .pc2_out(pc2_out),
    .rd_out(rd_out), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_ctrl = '0; m_opa = '0; m_opb = '0; m_imm = '0; m_pc2 = '0; m_rd = '0;
  endtask

  // One clock edge as the rules describe it, using the currently driven inputs.
  task automatic model_edge();
`ifdef IDEX_PERF_EN
    if (!m_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`endif
    if (flush) model_clear();
    else if (stall) ;
    else if (m_halted) model_clear();
    else begin
      m_valid = valid_in; m_ctrl = control_in; m_opa = opa_in; m_opb = opb_in;
      m_imm = imm_in; m_pc2 = pc2_in; m_rd = rd_in;
      if (valid_in && control_in[35]) m_halted = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},  valid_out,   m_valid);
    chk({tag, ".ctrl"},   control_out, m_ctrl);
    chk({tag, ".opa"},    opa_out,     m_opa);
    chk({tag, ".opb"},    opb_out,     m_opb);
    chk({tag, ".imm"},    imm_out,     m_imm);
    chk({tag, ".pc2"},    pc2_out,     m_pc2);
    chk({tag, ".rd"},     rd_out,      m_rd);
    chk({tag, ".halted"}, halted,      m_halted);
    chk({tag, ".bcnt"},   bubble_cnt,  m_cnt);
  endtask

  task automatic set_in(input logic st, input logic fl, input logic v, input logic [35:0] c,
                        input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd);
    stall = st; flush = fl; valid_in = v; control_in = c; opa_in = a; opb_in = b;
    imm_in = a ^ 16'h0F0F; pc2_in = b + 16'd2; rd_in = rd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any edge.
  task automatic do_reset(input string tag);
    rst = 1; #2;
    chk({tag, ".rst_valid"},  valid_out,   1'b0);
    chk({tag, ".rst_ctrl"},   control_out, 36'h0);
    chk({tag, ".rst_opa"},    opa_out,     16'h0);
    chk({tag, ".rst_rd"},     rd_out,      3'd0);
    chk({tag, ".rst_halted"}, halted,      1'b0);
    chk({tag, ".rst_bcnt"},   bubble_cnt,  16'h0);
    model_clear(); m_halted = 0; m_cnt = 0;
    #1 rst = 0;
  endtask

  typedef struct {
    logic st, fl, v; logic [35:0] c; logic [15:0] a; logic [2:0] rd;
    logic ev; logic [35:0] ec; logic [15:0] ea; logic [2:0] erd; logic eh;
  } vec_t;

  vec_t vt[10];

  initial begin
    rst = 1; set_in(0, 0, 0, '0, '0, '0, '0);
    model_clear(); m_halted = 0; m_cnt = 0;
    @(posedge clk); #1;
    check_model("reset");
    rst = 0;

    vt[0] = '{0,0,1,36'h0_0000_1234,16'hBEEF,3'd5, 1,36'h0_0000_1234,16'hBEEF,3'd5,0};
    vt[1] = '{1,0,1,36'h0,          16'h0002,3'd1, 1,36'h0_0000_1234,16'hBEEF,3'd5,0};
    vt[2] = '{0,0,0,36'h0_0000_00FF,16'h1111,3'd2, 0,36'h0_0000_00FF,16'h1111,3'd2,0};
    vt[3] = '{0,0,0,36'h8_0000_0000,16'h0000,3'd0, 0,36'h8_0000_0000,16'h0000,3'd0,0};
    vt[4] = '{0,1,1,36'h8_0000_0000,16'h4444,3'd4, 0,36'h0,          16'h0000,3'd0,0};
    vt[5] = '{1,1,1,36'h0_0000_1234,16'h3333,3'd3, 0,36'h0,          16'h0000,3'd0,0};
    vt[6] = '{0,0,1,36'h8_0000_0001,16'h7777,3'd7, 1,36'h8_0000_0001,16'h7777,3'd7,1};
    vt[7] = '{1,0,1,36'h0_0000_0005,16'h5555,3'd6, 1,36'h8_0000_0001,16'h7777,3'd7,1};
    vt[8] = '{0,0,1,36'h0_0000_0005,16'h5555,3'd6, 0,36'h0,          16'h0000,3'd0,1};
    vt[9] = '{0,0,1,36'h0_0000_0005,16'h5555,3'd6, 0,36'h0,          16'h0000,3'd0,1};
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].st, vt[i].fl, vt[i].v, vt[i].c, vt[i].a, 16'h0, vt[i].rd);
      tick();
      chk($sformatf("vec%0d.valid", i),  valid_out,   vt[i].ev);
      chk($sformatf("vec%0d.ctrl", i),   control_out, vt[i].ec);
      chk($sformatf("vec%0d.opa", i),    opa_out,     vt[i].ea);
      chk($sformatf("vec%0d.rd", i),     rd_out,      vt[i].erd);
      chk($sformatf("vec%0d.halted", i), halted,      vt[i].eh);
      chk($sformatf("vec%0d.bcnt", i),   bubble_cnt,  m_cnt);
    end
    do_reset("vec_end");

    // stall hold for 3 edges, then flush+stall bubble
    set_in(0, 0, 1, 36'h0_0000_0042, 16'h0001, 16'hAAAA, 3'd3); tick();
    chk("stall.load_opa", opa_out, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 36'h0_0000_0099, 16'h0002, 16'hBBBB, 3'd4); tick();
      chk($sformatf("stall.hold%0d_opa", i), opa_out, 16'h0001);
      chk($sformatf("stall.hold%0d_valid", i), valid_out, 1'b1);
    end
    set_in(1, 1, 1, 36'h0_0000_0099, 16'h0002, 16'hBBBB, 3'd4); tick();
    chk("flushstall.valid", valid_out, 1'b0);
    chk("flushstall.ctrl", control_out, 36'h0);
    chk("flushstall.opa", opa_out, 16'h0);
    check_model("flushstall");

    // halt drain with stall held 2 edges
    set_in(0, 0, 1, 36'h8_0000_00A5, 16'h9999, 16'h1212, 3'd2); tick();
    chk("halt.halted", halted, 1'b1);
    chk("halt.entry_opa", opa_out, 16'h9999);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 1, 36'h0, 16'h5555, 16'h5555, 3'd1); tick();
      chk($sformatf("halt.stall%0d_ctrl", i), control_out, 36'h8_0000_00A5);
      chk($sformatf("halt.stall%0d_valid", i), valid_out, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, 36'h0_0000_0001, 16'h5555, 16'h5555, 3'd1); tick();
      chk($sformatf("drain%0d.valid", i), valid_out, 1'b0);
      chk($sformatf("drain%0d.opa", i), opa_out, 16'h0);
      chk($sformatf("drain%0d.halted", i), halted, 1'b1);
      check_model($sformatf("drain%0d", i));
    end
    do_reset("halt_rst");   // valid inputs still driven while rst asserted

    // mid-stream reset with a valid entry loaded
    set_in(0, 0, 1, 36'h0_0000_0777, 16'hCAFE, 16'h0101, 3'd6); tick();
    chk("mid.valid", valid_out, 1'b1);
    do_reset("mid");

    // ignored halts: not valid, or offered under flush
    set_in(0, 0, 0, 36'h8_0000_0000, 16'h0, 16'h0, 3'd0); tick();
    chk("ign_nv.halted", halted, 1'b0);
    set_in(0, 1, 1, 36'h8_0000_0000, 16'h0, 16'h0, 3'd0); tick();
    chk("ign_fl.halted", halted, 1'b0);
    set_in(1, 0, 1, 36'h8_0000_0000, 16'h0, 16'h0, 3'd0); tick();
    chk("ign_st.halted", halted, 1'b0);
    check_model("ign");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rnd");
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
             {($urandom_range(0, 15) == 0), 3'($urandom), 32'($urandom)},
             16'($urandom), 16'($urandom), 3'($urandom));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    // bubble counter
    do_reset("perf");
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 36'h0, 16'h0, 16'h0, 3'd0); tick();
    end
`ifdef IDEX_PERF_EN
    chk("perf.ten", bubble_cnt, 16'd10);
    for (int i = 0; i < 65540; i++) tick();
    chk("perf.sat", bubble_cnt, 16'hFFFF);
    tick();
    chk("perf.sat_hold", bubble_cnt, 16'hFFFF);
`else
    chk("perf.off", bubble_cnt, 16'h0);
`endif
    check_model("perf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
